// File: rtl/lift_call_scheduler.sv
// Three-stop lift call scheduler: latches calls, runs a SCAN sequencer,
// and times floor travel and door dwell from a prescaled tick.
module lift_call_scheduler #(
  parameter int NUM_FLOORS   = 3,
  parameter int HOME_FLOOR   = 1,
  parameter int TICK_DIV     = 50000000,
  parameter int TRAVEL_TICKS = 2,
  parameter int DOOR_TICKS   = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NUM_FLOORS-1:0] i_call_req,
  input  logic                  i_door_hold,
  output logic [1:0]            o_floor,
  output logic                  o_moving,
  output logic                  o_dir_up,
  output logic                  o_door_open,
  output logic                  o_arrive,
  output logic [NUM_FLOORS-1:0] o_pending
);

  localparam int NF   = NUM_FLOORS;
  localparam int PW   = $clog2(TICK_DIV);
  localparam int TMAX = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MOVE,
    S_OPEN
  } state_t;

  state_t          r_state;
  logic [1:0]      r_floor;
  logic            r_dir;
  logic            r_arrive;
  logic [NF-1:0]   r_pending;
  logic [PW-1:0]   r_pre;
  logic [TW-1:0]   r_ticks;

  logic            w_tick;
  logic            w_arr;
  logic [1:0]      w_next;
  logic [NF-1:0]   w_cur_bit;
  logic [NF-1:0]   w_new_bit;
  logic [NF-1:0]   w_served;
  logic [NF-1:0]   w_req;
  logic [NF-1:0]   w_fwd;
  logic [NF-1:0]   w_bwd;
  logic [NF-1:0]   w_fwd_new;

  function automatic logic [NF-1:0] above(input logic [1:0] f);
    logic [NF-1:0] m;
    for (int i = 0; i < NF; i++) m[i] = (i > int'(f));
    return m;
  endfunction

  function automatic logic [NF-1:0] below(input logic [1:0] f);
    logic [NF-1:0] m;
    for (int i = 0; i < NF; i++) m[i] = (i < int'(f));
    return m;
  endfunction

  assign w_tick = (r_pre == PW'(TICK_DIV - 1));
  assign w_arr  = (r_state == S_MOVE) && w_tick &&
                  (r_ticks == TW'(TRAVEL_TICKS - 1));

  // Next floor is clamped at both ends even though SCAN never asks past them
  always_comb begin
    w_next = r_floor;
    if (r_dir) begin
      if (r_floor != 2'(NF - 1)) w_next = r_floor + 2'd1;
    end else begin
      if (r_floor != 2'd0) w_next = r_floor - 2'd1;
    end
  end

  assign w_cur_bit = NF'(1) << r_floor;
  assign w_new_bit = NF'(1) << w_next;
  assign w_req     = r_pending | i_call_req;
  assign w_fwd     = r_dir ? above(r_floor) : below(r_floor);
  assign w_bwd     = r_dir ? below(r_floor) : above(r_floor);
  assign w_fwd_new = r_dir ? above(w_next) : below(w_next);

  always_comb begin
    w_served = '0;
    if (r_state != S_MOVE) w_served = w_cur_bit;
    else if (w_arr)        w_served = w_new_bit;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_floor   <= 2'(HOME_FLOOR);
      r_dir     <= 1'b1;
      r_arrive  <= 1'b0;
      r_pending <= '0;
      r_pre     <= '0;
      r_ticks   <= '0;
    end else begin
      r_pending <= w_req & ~w_served;
      r_arrive  <= 1'b0;
      r_pre     <= w_tick ? '0 : r_pre + 1'b1;
      unique case (r_state)
        S_IDLE: begin
          if (|(w_req & w_cur_bit)) begin
            r_state <= S_OPEN;
            r_pre   <= '0;
            r_ticks <= '0;
          end else if (|(r_pending & w_fwd)) begin
            r_state <= S_MOVE;
            r_pre   <= '0;
            r_ticks <= '0;
          end else if (|(r_pending & w_bwd)) begin
            r_state <= S_MOVE;
            r_dir   <= ~r_dir;
            r_pre   <= '0;
            r_ticks <= '0;
          end
        end
        S_MOVE: begin
          if (w_arr) begin
            r_floor  <= w_next;
            r_arrive <= 1'b1;
            r_ticks  <= '0;
            if (|(w_req & w_new_bit)) r_state <= S_OPEN;
            else if (!(|(r_pending & w_fwd_new))) r_state <= S_IDLE;
          end else if (w_tick) begin
            r_ticks <= r_ticks + 1'b1;
          end
        end
        S_OPEN: begin
          // A repeat call or held button restarts the whole dwell
          if (i_door_hold || |(i_call_req & w_cur_bit)) begin
            r_pre   <= '0;
            r_ticks <= '0;
          end else if (w_tick) begin
            if (r_ticks == TW'(DOOR_TICKS - 1)) begin
              r_state <= S_IDLE;
              r_ticks <= '0;
            end else begin
              r_ticks <= r_ticks + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_floor     = r_floor;
  assign o_moving    = (r_state == S_MOVE);
  assign o_dir_up    = r_dir;
  assign o_door_open = (r_state == S_OPEN);
  assign o_arrive    = r_arrive;
  assign o_pending   = r_pending;

endmodule

// File: doc/lift_call_scheduler.md
# lift_call_scheduler

Request scheduler and car sequencer for the three-stop lift. Latches cab and hall calls, picks travel direction using a collective (SCAN) policy, times floor-to-floor travel and door dwell from a 1 s tick, and reports car position and door state to the display and motor/door outputs. It sits between the debounced KEY/GPIO call inputs and the floor-indicator logic, replacing ad-hoc per-state request handling with one arbitrated pending-call register.

## Interface
- NUM_FLOORS, 3, number of stops; legal 2..4; floor 0 is the basement.
- HOME_FLOOR, 1, floor loaded at reset.
- TICK_DIV, 50000000, clk cycles per tick; must be at least 2.
- TRAVEL_TICKS, 2, ticks per one-floor move; must be at least 1.
- DOOR_TICKS, 3, ticks of door dwell; must be at least 1.
- clk  in  1  system clock; 50 MHz on the board.
- rst  in  1  reset; synchronous, active-high. Driven from SW[0].
- call_req  in  NUM_FLOORS  active-high call pulses, one bit per floor, already debounced and inverted from KEY/GPIO. Bits may be held high for several cycles.
- door_hold  in  1  level; while high in OPEN, dwell restarts every cycle.
- floor  out  2  current or last-passed floor.
- moving  out  1  high in MOVE.
- dir_up  out  1  1 = up, 0 = down; valid while moving, otherwise holds the last direction.
- door_open  out  1  high in OPEN.
- arrive  out  1  one-cycle pulse on each floor change.
- pending  out  NUM_FLOORS  latched unserved calls.

## Operation
- **Reset values:** state=IDLE, floor=HOME_FLOOR, dir_up=1, moving=0, door_open=0, arrive=0, pending=0, prescaler=0, tick counter=0.
- **Prescaler:** counts 0..TICK_DIV-1 and produces a one-cycle tick at TICK_DIV-1. Both the prescaler and the tick counter clear on every state transition, so dwell and travel times are exact.
- **Latching:** each cycle, pending <= (pending | call_req) & ~served.
  - served = the current-floor bit when state is IDLE or OPEN.
  - served = the arrival-floor bit on the arrival edge.
  - A call for the current floor is never latched. It opens the door (IDLE) or restarts dwell (OPEN).
  - A current-floor call during MOVE is latched and served on a later visit.
- **IDLE:**
  - If call_req or pending has the current-floor bit set, go to OPEN.
  - Else, if pending has any bit strictly ahead in dir_up, go to MOVE keeping dir_up.
  - Else, if pending has any bit behind, toggle dir_up and go to MOVE.
  - Else stay in IDLE.
- **MOVE:**
  - After TRAVEL_TICKS ticks, floor <= floor ±1 and arrive pulses.
  - If pending has the new-floor bit set, clear it and go to OPEN.
  - Else, if any pending bit lies further ahead, reload the counter and stay in MOVE.
  - Else go to IDLE.
  - floor never leaves 0..NUM_FLOORS-1. Direction selection guarantees this; a defensive clamp is also required.
- **OPEN:**
  - Dwell lasts DOOR_TICKS ticks.
  - A current-floor call_req or door_hold=1 clears the prescaler and tick counter.
  - At the end of dwell, go to IDLE.
- **Simultaneous events:**
  - A call_req bit for the arrival floor on the arrival edge is treated as served and not latched.
  - rst overrides everything in any state, including mid-MOVE. Nothing is retained.

## Timing
- Registered outputs; no combinational path from inputs to outputs.
- call_req at edge k: pending visible at k+1; moving=1 at k+2.
- MOVE lasts exactly TRAVEL_TICKS*TICK_DIV cycles per floor. The floor update, arrive pulse and door_open=1 all land on the same edge.
- OPEN lasts exactly DOOR_TICKS*TICK_DIV cycles after the last restart. door_open falls on the edge that enters IDLE.
- A current-floor call in IDLE gives door_open=1 on the next edge.

## Test plan
Bench parameters: NUM_FLOORS=3, HOME_FLOOR=1, TICK_DIV=4, TRAVEL_TICKS=3, DOOR_TICKS=2.
- **Reset:** assert rst for 2 cycles -> floor=1, dir_up=1, moving=0, door_open=0, arrive=0, pending=000.
- **Single up call:** call_req=100 for 1 cycle at cycle 0 -> pending=100 at cycle 1; moving=1, dir_up=1 at cycle 2; floor=2, arrive, door_open=1 at cycle 14; door_open=0 at cycle 22; pending=000.
- **Current-floor call in IDLE:** call_req=010 -> door_open=1 next cycle for 8 cycles; pending stays 000.
- **Reversal:** call_req=100, then call_req=001 at cycle 5 while moving up -> serves floor 2 first, then dir_up=0. Passes floor 1 without stopping (arrive pulse, no door_open). Opens at floor 0; pending=000 at the end.
- **Door hold:** in OPEN, hold door_hold=1 for 20 cycles, then release -> door_open stays 1 throughout and falls exactly 8 cycles after release.
- **Reset mid-MOVE:** pending=101, rst asserted while moving -> next cycle floor=1, moving=0, pending=000; no arrive pulse afterwards.
